mips_cache_controller: RTL and testbench
========================================

// Module: mips_cache_controller
// PURPOSE
//   Miss/write-through engine between mips_cache_data and the Avalon memory bus.
//   On a data-cache miss (stall high) it fetches the word at data_addr from memory.
//   It returns the word as data_in together with a one-cycle data_valid pulse.
//   CPU stores are forwarded to memory as byte-enabled Avalon writes (write-through).
// PARAMETERS
//   TIMEOUT_CYCLES  255  consecutive waitrequest-high cycles in one request before ERROR
// PORTS
//   clk              in   1   system clock, all logic on posedge
//   rst              in   1   synchronous, active-high reset
//   stall            in   1   miss indication from mips_cache_data
//   data_addr        in   32  miss/store byte address from mips_cache_data
//   cpu_write_en     in   1   CPU store request this cycle
//   cpu_writedata    in   32  CPU store data
//   cpu_byte_en      in   4   CPU store byte lanes
//   data_in          out  32  fetched word to cache
//   data_valid       out  1   one-cycle pulse: data_in valid
//   write_busy       out  1   store in flight; CPU must hold
//   mem_address      out  32  Avalon address, word-aligned ([1:0]=0)
//   mem_read         out  1   Avalon read
//   mem_write        out  1   Avalon write
//   mem_writedata    out  32  Avalon write data
//   mem_byteenable   out  4   Avalon byte enables (4'b1111 on reads)
//   mem_waitrequest  in   1   Avalon stall from memory
//   mem_readdata     in   32  Avalon read data
//   timeout_err      out  1   sticky bus-timeout flag
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; timeout counter 0.
//   Reset mid-transaction: mem_read/mem_write drop at the reset edge; the transfer is abandoned.
//   FSM states: IDLE, RD_REQ, RD_DONE, WR_REQ, ERROR.
//   IDLE:
//     - cpu_write_en & |cpu_byte_en: latch {data_addr[31:2],2'b00}, writedata and byte_en -> WR_REQ.
//     - else if stall: latch the aligned address -> RD_REQ.
//     - A store has priority over a simultaneous miss; the miss is serviced after the store completes.
//     - cpu_write_en with byte_en==0 is ignored.
//   RD_REQ:
//     - mem_read=1 and mem_address held from the latch; data_addr changes are ignored.
//     - On a cycle with waitrequest=0: data_in<=mem_readdata -> RD_DONE.
//   RD_DONE: data_valid=1 for exactly this cycle -> IDLE.
//     - The cache fills at this edge, so stall is low on the next IDLE cycle.
//   WR_REQ:
//     - mem_write=1, write_busy=1, latched data and byte enables driven.
//     - On a cycle with waitrequest=0 -> IDLE; write_busy is low from the next cycle.
//   Latency:
//     - Miss seen in IDLE at cycle 0 -> mem_read at cycle 1.
//     - With zero wait states, data_valid at cycle 2.
//     - Each waitrequest-high cycle adds 1.
//   Timeout:
//     - The counter increments on each REQ cycle with waitrequest=1 and clears on request accept.
//     - When the counter reaches TIMEOUT_CYCLES: -> ERROR.
//   ERROR: mem_read/mem_write=0, timeout_err=1, write_busy=1; exit only via rst.
//   mem_read and mem_write are never high together; mem_* outputs are driven from registers.
// TESTING
//   1. Read miss, zero wait:
//      stall=1, addr=0x1000_0007, readdata=0xDEADBEEF ->
//      mem_address=0x1000_0004 at cycle 1; data_valid=1, data_in=0xDEADBEEF at cycle 2.
//   2. Read miss, 3 wait states ->
//      mem_read held 4 cycles with a stable address; data_valid at cycle 5, single pulse.
//   3. Store, byte_en=4'b0011, data=0x1234_5678 ->
//      mem_write=1, mem_byteenable=0011, write_busy=1 until accept; then IDLE.
//   4. Store and miss in the same cycle ->
//      write completes first, then mem_read is issued; data_valid follows the read.
//   5. waitrequest held high > 255 cycles ->
//      ERROR, mem_read=0, timeout_err=1 sticky; rst clears all outputs.
//   6. rst asserted during RD_REQ ->
//      next cycle: mem_read=0, data_valid never pulses; a subsequent miss is serviced normally.

Source files
------------

// File: rtl/mips_cache_controller_if.sv
// mips_cache_controller_if: Avalon memory bus between the cache controller and memory.
interface mips_cache_controller_if;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   modport master (
      output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
      input  mem_waitrequest, mem_readdata
   );
   modport slave (
      input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
      output mem_waitrequest, mem_readdata
   );
endinterface

// File: rtl/mips_cache_controller.sv
// mips_cache_controller: miss-fetch and write-through engine between the data cache and Avalon memory.
module mips_cache_controller #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] data_addr,
   input  logic        cpu_write_en,
   input  logic [31:0] cpu_writedata,
   input  logic [3:0]  cpu_byte_en,
   output logic [31:0] data_in,
   output logic        data_valid,
   output logic        write_busy,
   output logic        timeout_err,
   mips_cache_controller_if.master bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DONE, WR_REQ, ERROR} state_t;
   state_t        state, next;
   logic [CW-1:0] cnt;
   logic          is_req, start_wr, timeout;
   always_comb begin
      next     = state;
      is_req   = state == RD_REQ || state == WR_REQ;
      start_wr = cpu_write_en && |cpu_byte_en;
      timeout  = is_req && bus.mem_waitrequest && cnt == CW'(TIMEOUT_CYCLES - 1);
      case (state)
         IDLE:    next = start_wr ? WR_REQ : stall ? RD_REQ : IDLE;
         RD_REQ:  next = timeout ? ERROR : bus.mem_waitrequest ? RD_REQ : RD_DONE;
         RD_DONE: next = IDLE;
         WR_REQ:  next = timeout ? ERROR : bus.mem_waitrequest ? WR_REQ : IDLE;
         default: next = ERROR;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= next;
   // Outputs are registered from next-state so the bus sees clean register outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt                <= '0;
         data_in            <= '0;
         data_valid         <= 1'b0;
         write_busy         <= 1'b0;
         timeout_err        <= 1'b0;
         bus.mem_address    <= '0;
         bus.mem_read       <= 1'b0;
         bus.mem_write      <= 1'b0;
         bus.mem_writedata  <= '0;
         bus.mem_byteenable <= '0;
      end else begin
         cnt           <= is_req && bus.mem_waitrequest ? cnt + 1'b1 : '0;
         data_valid    <= next == RD_DONE;
         write_busy    <= next == WR_REQ || next == ERROR;
         timeout_err   <= next == ERROR;
         bus.mem_read  <= next == RD_REQ;
         bus.mem_write <= next == WR_REQ;
         if (state == IDLE && next != IDLE) begin
            bus.mem_address    <= {data_addr[31:2], 2'b00};
            bus.mem_byteenable <= start_wr ? cpu_byte_en : 4'b1111;
            if (start_wr) bus.mem_writedata <= cpu_writedata;
         end
         if (state == RD_REQ && !bus.mem_waitrequest) data_in <= bus.mem_readdata;
      end
   end
endmodule

// File: tb/tb_mips_cache_controller.sv
// tb_mips_cache_controller: directed self-checking bench for mips_cache_controller.
module tb_mips_cache_controller;
   logic        clk = 1'b0;
   logic        rst, stall, cpu_write_en;
   logic [31:0] data_addr, cpu_writedata, data_in;
   logic [3:0]  cpu_byte_en;
   logic        data_valid, write_busy, timeout_err;
   int          checks = 0, errors = 0;
   mips_cache_controller_if bus ();
   mips_cache_controller dut (
      .clk(clk), .rst(rst), .stall(stall), .data_addr(data_addr),
      .cpu_write_en(cpu_write_en), .cpu_writedata(cpu_writedata), .cpu_byte_en(cpu_byte_en),
      .data_in(data_in), .data_valid(data_valid), .write_busy(write_busy),
      .timeout_err(timeout_err), .bus(bus.master)
   );
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; cpu_write_en = 1'b0; data_addr = '0;
      cpu_writedata = '0; cpu_byte_en = '0;
      bus.mem_waitrequest = 1'b0; bus.mem_readdata = '0;
      step(); step();
      check("rst_valid", data_valid, 0);
      check("rst_read", bus.mem_read, 0);
      check("rst_write", bus.mem_write, 0);
      check("rst_busy", write_busy, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_addr", bus.mem_address, 0);
      rst = 1'b0;
      step();

      // 1: read miss, zero wait
      stall = 1'b1; data_addr = 32'h1000_0007; bus.mem_readdata = 32'hDEADBEEF;
      step();
      check("t1_read", bus.mem_read, 1);
      check("t1_addr", bus.mem_address, 32'h1000_0004);
      check("t1_be", bus.mem_byteenable, 4'hF);
      check("t1_dv_c1", data_valid, 0);
      step();
      check("t1_dv", data_valid, 1);
      check("t1_data", data_in, 32'hDEADBEEF);
      check("t1_read_off", bus.mem_read, 0);
      stall = 1'b0;
      step();
      check("t1_dv_pulse", data_valid, 0);

      // 2: read miss, three wait states
      stall = 1'b1; data_addr = 32'h2000_0010; bus.mem_waitrequest = 1'b1;
      bus.mem_readdata = 32'hCAFEF00D;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("t2_read_c%0d", k), bus.mem_read, 1);
         check($sformatf("t2_addr_c%0d", k), bus.mem_address, 32'h2000_0010);
         check($sformatf("t2_dv_c%0d", k), data_valid, 0);
         data_addr = 32'h2BAD_0000;
         if (k == 4) bus.mem_waitrequest = 1'b0;
      end
      step();
      check("t2_dv", data_valid, 1);
      check("t2_data", data_in, 32'hCAFEF00D);
      stall = 1'b0;
      step();
      check("t2_dv_pulse", data_valid, 0);
      check("t2_read_off", bus.mem_read, 0);

      // byte_en == 0 store is ignored
      cpu_write_en = 1'b1; cpu_byte_en = 4'b0000;
      step();
      check("nobe_write", bus.mem_write, 0);
      check("nobe_busy", write_busy, 0);

      // 3: store with wait states
      cpu_byte_en = 4'b0011; cpu_writedata = 32'h1234_5678; data_addr = 32'h3000_0002;
      bus.mem_waitrequest = 1'b1;
      step();
      cpu_write_en = 1'b0;
      check("t3_write", bus.mem_write, 1);
      check("t3_read", bus.mem_read, 0);
      check("t3_busy", write_busy, 1);
      check("t3_be", bus.mem_byteenable, 4'b0011);
      check("t3_wdata", bus.mem_writedata, 32'h1234_5678);
      check("t3_addr", bus.mem_address, 32'h3000_0000);
      step();
      check("t3_busy_hold", write_busy, 1);
      bus.mem_waitrequest = 1'b0;
      step();
      check("t3_busy_off", write_busy, 0);
      check("t3_write_off", bus.mem_write, 0);

      // 4: store and miss in the same cycle
      cpu_write_en = 1'b1; cpu_byte_en = 4'b1111; cpu_writedata = 32'hA5A5_A5A5;
      stall = 1'b1; data_addr = 32'h4000_0008; bus.mem_readdata = 32'h1122_3344;
      step();
      cpu_write_en = 1'b0;
      check("t4_write_first", bus.mem_write, 1);
      check("t4_no_read", bus.mem_read, 0);
      step();
      check("t4_idle_write", bus.mem_write, 0);
      check("t4_idle_read", bus.mem_read, 0);
      step();
      check("t4_read", bus.mem_read, 1);
      check("t4_addr", bus.mem_address, 32'h4000_0008);
      check("t4_be", bus.mem_byteenable, 4'hF);
      step();
      check("t4_dv", data_valid, 1);
      check("t4_data", data_in, 32'h1122_3344);
      stall = 1'b0;
      step();

      // 6: reset during RD_REQ
      stall = 1'b1; data_addr = 32'h5000_0000; bus.mem_waitrequest = 1'b1;
      step();
      check("t6_read", bus.mem_read, 1);
      rst = 1'b1;
      step();
      check("t6_read_drop", bus.mem_read, 0);
      check("t6_dv_rst", data_valid, 0);
      rst = 1'b0; stall = 1'b0; bus.mem_waitrequest = 1'b0;
      step();
      check("t6_dv_after", data_valid, 0);
      stall = 1'b1; data_addr = 32'h6000_000C; bus.mem_readdata = 32'h0BAD_F00D;
      step();
      check("t6_read2", bus.mem_read, 1);
      check("t6_addr2", bus.mem_address, 32'h6000_000C);
      step();
      check("t6_dv2", data_valid, 1);
      check("t6_data2", data_in, 32'h0BAD_F00D);
      stall = 1'b0;
      step();

      // 5: bus timeout after 255 waitrequest-high cycles
      stall = 1'b1; data_addr = 32'h7000_0000; bus.mem_waitrequest = 1'b1;
      step();
      check("t5_read_c1", bus.mem_read, 1);
      repeat (254) step();
      check("t5_read_c255", bus.mem_read, 1);
      check("t5_terr_c255", timeout_err, 0);
      step();
      check("t5_read_off", bus.mem_read, 0);
      check("t5_terr", timeout_err, 1);
      check("t5_busy", write_busy, 1);
      stall = 1'b0; bus.mem_waitrequest = 1'b0;
      repeat (3) step();
      check("t5_terr_sticky", timeout_err, 1);
      check("t5_read_stuck", bus.mem_read, 0);
      rst = 1'b1;
      step();
      check("t5_rst_terr", timeout_err, 0);
      check("t5_rst_busy", write_busy, 0);
      check("t5_rst_addr", bus.mem_address, 0);
      check("t5_rst_data", data_in, 0);
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
